// File: rtl/tft_spi_sender.sv
// Byte-wide SPI (mode 0, MSB first) sender for a TFT panel with D/C and chip select.
// Define TFT_SPI_FIFO_EN to place a 4-entry {dc,data} FIFO between acceptance and the shifter.
module tft_spi_sender #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       fsm_state
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state, state_next;
  logic [HW-1:0] hcnt, hcnt_next;
  logic [2:0]    bcnt, bcnt_next;
  logic          phase, phase_next;
  logic [7:0]    shreg, shreg_next;
  logic          dc_r, dc_next;
  logic          accept, load, done, busy_next;
  logic [8:0]    head;

  // Handshake: a byte is taken on any rising edge where tft_transmit=1, tft_busy=0
  // and rst=0; a strobe seen while busy is dropped, never queued.
  assign accept = tft_transmit & ~tft_busy & ~rst;

`ifdef TFT_SPI_FIFO_EN
  logic [8:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count, count_next;

  assign load       = (state == IDLE) && (count != 3'd0);
  assign head       = fifo_mem[rd_ptr];
  assign count_next = count + 3'(accept) - 3'(load);
  assign busy_next  = (count_next == 3'd4);

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= {tft_dc, tft_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (load)   rd_ptr <= rd_ptr + 2'd1;
      count <= count_next;
    end
  end
`else
  // The shifter itself is the capture register: the byte loads on the accept edge.
  assign load      = accept;
  assign head      = {tft_dc, tft_data};
  assign busy_next = accept | (tft_busy & ~done);
`endif

  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    bcnt_next  = bcnt;
    phase_next = phase;
    shreg_next = shreg;
    dc_next    = dc_r;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = SHIFT;
          shreg_next = head[7:0];
          dc_next    = head[8];
          hcnt_next  = '0;
          bcnt_next  = '0;
          phase_next = 1'b0;
        end
      end
      SHIFT: begin
        if (hcnt == HLAST) begin
          hcnt_next = '0;
          if (!phase) begin
            phase_next = 1'b1;
          end else begin
            // Falling SCLK: advance MOSI while the clock is low.
            phase_next = 1'b0;
            shreg_next = {shreg[6:0], 1'b0};
            bcnt_next  = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              done       = 1'b1;
              state_next = IDLE;
            end
          end
        end else begin
          hcnt_next = hcnt + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
      shreg    <= '0;
      dc_r     <= 1'b0;
      tft_busy <= 1'b0;
    end else begin
      state    <= state_next;
      hcnt     <= hcnt_next;
      bcnt     <= bcnt_next;
      phase    <= phase_next;
      shreg    <= shreg_next;
      dc_r     <= dc_next;
      tft_busy <= busy_next;
    end
  end

  assign spi_cs_n  = (state != SHIFT);
  assign spi_sclk  = (state == SHIFT) & phase;
  assign spi_mosi  = (state == SHIFT) & shreg[7];
  assign spi_dc    = dc_r;
  assign fsm_state = (state == SHIFT);

endmodule

// File: tb/tb_tft_spi_sender.sv
// Bench for tft_spi_sender: CLK_DIV=1 and CLK_DIV=2 instances, directed bytes, queue scoreboard.
module tb_tft_spi_sender;

  logic       clk;
  logic [1:0] rst, tx, dcin;
  logic [7:0] din [2];
  wire  [1:0] busy, sclk, mosi, csn, sdc, st;

  // instance g has CLK_DIV = g+1
  for (genvar g = 0; g < 2; g++) begin : g_dut
    tft_spi_sender #(.CLK_DIV(g + 1)) dut (
      .clk(clk), .rst(rst[g]), .tft_transmit(tx[g]), .tft_dc(dcin[g]),
      .tft_data(din[g]), .tft_busy(busy[g]), .spi_sclk(sclk[g]),
      .spi_mosi(mosi[g]), .spi_cs_n(csn[g]), .spi_dc(sdc[g]), .fsm_state(st[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;

  // {abort_expected, dc, data}
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];

  task automatic check(input bit ok, input string name, input int act, input int expv);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // ---------------- monitor ----------------
  bit         mon_en = 0;
  logic [1:0] p_sclk = 2'b00, p_csn = 2'b11, p_mosi = 2'b00;
  int         bits[2], lowc[2], highc[2];
  logic [7:0] word[2];
  bit         gap_chk[2];

  task automatic frame_end(input int i);
    logic [9:0] e;
    int n;
    n = qsize(i);
    check(n != 0, "frame_expected", n, 1);
    if (n != 0) begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (e[9]) begin
        check(bits[i] == 3, "abort_bits", bits[i], 3);
      end else begin
        check(bits[i] == 8, "bit_count", bits[i], 8);
        check(word[i] == e[7:0], "byte", word[i], e[7:0]);
        check(sdc[i] == e[8], "spi_dc", sdc[i], e[8]);
        check(lowc[i] == 16 * (i + 1), "cs_low_cycles", lowc[i], 16 * (i + 1));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (p_csn[i] && !csn[i]) begin
          if (gap_chk[i]) check(highc[i] == 1, "cs_gap", highc[i], 1);
          highc[i] = 0; lowc[i] = 0; bits[i] = 0; word[i] = 8'h00;
        end
        if (!csn[i]) begin
          lowc[i]++;
          if (sclk[i] && !p_sclk[i]) begin
            word[i] = {word[i][6:0], mosi[i]};
            bits[i]++;
          end
          if (sclk[i] && p_sclk[i]) check(mosi[i] == p_mosi[i], "mosi_stable", mosi[i], p_mosi[i]);
        end else begin
          highc[i]++;
          check(sclk[i] == 1'b0 && mosi[i] == 1'b0, "idle_lines", {sclk[i], mosi[i]}, 0);
        end
        if (!p_csn[i] && csn[i]) frame_end(i);
        p_sclk[i] = sclk[i];
        p_csn[i]  = csn[i];
        p_mosi[i] = mosi[i];
      end
    end
  end

  bit busy_seen = 0;
  always @(negedge clk) if (busy[1] === 1'b1) busy_seen = 1;

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [8:0] w, input bit abort);
    int n = 0;
    while (busy[i] && n < 400) begin @(negedge clk); n++; end
    check(n < 400, "busy_wait", n, 400);
    if (i == 0) exp_q0.push_back({abort, w}); else exp_q1.push_back({abort, w});
    tx[i] = 1'b1; dcin[i] = w[8]; din[i] = w[7:0];
    @(negedge clk);
    tx[i] = 1'b0;
  endtask

  task automatic busy_len(input int i, output int n);
    n = 0;
    while (busy[i] && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((csn[i] !== 1'b1 || qsize(i) != 0) && n < 2000) begin @(negedge clk); n++; end
    check(n < 2000, "drain_timeout", n, 2000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r;
    logic ps;
    rst = 2'b11; tx = 2'b00; dcin = 2'b00; din[0] = 8'h00; din[1] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(csn[i] == 1'b1, "rst_cs_n", csn[i], 1);
      check(sclk[i] == 1'b0, "rst_sclk", sclk[i], 0);
      check(mosi[i] == 1'b0, "rst_mosi", mosi[i], 0);
      check(sdc[i] == 1'b0, "rst_dc", sdc[i], 0);
      check(busy[i] == 1'b0, "rst_busy", busy[i], 0);
    end
    rst = 2'b00;
    mon_en = 1;
    @(negedge clk);

    // 0xA5 data byte, CLK_DIV=2
    send(1, {1'b1, 8'hA5}, 1'b0);
`ifndef TFT_SPI_FIFO_EN
    busy_len(1, n);
    check(n == 32, "busy_len_div2", n, 32);
`endif

    // CLK_DIV=1: data byte, then command byte with rejected strobe while busy
    send(0, {1'b1, 8'h5A}, 1'b0);
`ifndef TFT_SPI_FIFO_EN
    busy_len(0, n);
    check(n == 16, "busy_len_div1", n, 16);
    send(0, {1'b0, 8'h3C}, 1'b0);
    tx[0] = 1'b1; dcin[0] = 1'b1; din[0] = 8'hFF;
    n = 0;
    while (busy[0] && n < 100) begin @(negedge clk); n++; end
    tx[0] = 1'b0;
    check(n == 16, "busy_reject_len", n, 16);
`endif

    // mid-byte reset after the 3rd SCLK rise
    wait_idle(1);
    send(1, {1'b1, 8'h81}, 1'b1);
    r = 0; n = 0; ps = sclk[1];
    while (r < 3 && n < 400) begin
      @(negedge clk); n++;
      if (sclk[1] && !ps) r++;
      ps = sclk[1];
    end
    check(r == 3, "sclk_rises_before_rst", r, 3);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check(csn[1] == 1'b1, "midrst_cs_n", csn[1], 1);
    check(sclk[1] == 1'b0, "midrst_sclk", sclk[1], 0);
    check(busy[1] == 1'b0, "midrst_busy", busy[1], 0);
    check(sdc[1] == 1'b0, "midrst_dc", sdc[1], 0);
    check(st[1] == 1'b0, "midrst_state", st[1], 0);
    send(1, {1'b0, 8'h42}, 1'b0);

`ifndef TFT_SPI_FIFO_EN
    // back-to-back: one IDLE cycle between bytes
    wait_idle(1);
    send(1, {1'b0, 8'h2A}, 1'b0);
    @(negedge clk);
    gap_chk[1] = 1;
    send(1, {1'b0, 8'h00}, 1'b0);
    send(1, {1'b0, 8'h10}, 1'b0);
    wait_idle(1);
    gap_chk[1] = 0;
`else
    // FIFO fill: six bytes pushed whenever not busy
    wait_idle(1);
    busy_seen = 0;
    for (int j = 1; j <= 6; j++) send(1, {1'b0, 8'(j)}, 1'b0);
    wait_idle(1);
    check(busy_seen == 1, "fifo_full_busy", busy_seen, 1);
`endif

    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk);
    check(qsize(0) == 0, "q0_empty", qsize(0), 0);
    check(qsize(1) == 0, "q1_empty", qsize(1), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
